ldpc_encoder_8640: RTL and testbench

- Rate-1/2 LDPC encoder, N=8640, K=4320; the transmit-side counterpart of the 8640-bit layered LDPC decoder.
- Captures 4320 serial info bits after frame_start and computes 4320 parity bits with IRA/accumulator structure.
- Emits the systematic codeword serially: info bits first, then parity.
- Parity-check addressing comes from a group ROM: group size 72, q=60.

---
 rtl/ldpc_enc_pkg.sv | 65 ++++++
 rtl/enc_addr_rom.sv | 19 +
 rtl/ldpc_encoder_8640.sv | 204 ++++++++++++++++++++
 tb/tb_ldpc_encoder_8640.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_enc_pkg.sv
// rtl/ldpc_enc_pkg.sv - shared constants, state encoding and group ROM image for the 8640-bit LDPC encoder
package ldpc_enc_pkg;

    localparam int N_CODE    = 8640;
    localparam int K_INFO    = 4320;
    localparam int M_PAR     = 4320;
    localparam int GRP_SIZE  = 72;
    localparam int Q_STEP    = 60;
    localparam int N_GROUPS  = 60;
    localparam int ROM_AW    = 8;
    localparam int ROM_DEPTH = 1 << ROM_AW;
    localparam int ROM_W     = 14;
    localparam int BASE_W    = 13;
    localparam int ROM_LAST_BIT = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ENC  = 2'd2,
        OUT  = 2'd3
    } state_t;

    typedef struct packed {
        logic              last;
        logic [BASE_W-1:0] base;
    } rom_word_t;

    typedef logic [ROM_DEPTH-1:0][ROM_W-1:0] rom_img_t;
    typedef logic [N_GROUPS:0][ROM_AW-1:0]   row_ptr_t;

    // Even-quarter groups carry two checks per member, the rest one.
    function automatic int row_entries(input int g);
        return (g % 4 == 0) ? 2 : 1;
    endfunction

    function automatic logic [BASE_W-1:0] row_base(input int g, input int e);
        return (e == 0) ? BASE_W'(g * 71) : BASE_W'(2160 + g * 13);
    endfunction

    function automatic rom_img_t build_rom();
        rom_img_t img;
        int       a;
        img = '0;
        a   = 0;
        for (int g = 0; g < N_GROUPS; g++) begin
            for (int e = 0; e < row_entries(g); e++) begin
                img[a] = {(e == row_entries(g) - 1), row_base(g, e)};
                a++;
            end
        end
        return img;
    endfunction

    function automatic row_ptr_t build_row_ptr();
        row_ptr_t p;
        p = '0;
        for (int g = 0; g < N_GROUPS; g++) begin
            p[g + 1] = p[g] + ROM_AW'(row_entries(g));
        end
        return p;
    endfunction

    localparam rom_img_t ROM_IMG = build_rom();

endpackage

// File: rtl/enc_addr_rom.sv
// rtl/enc_addr_rom.sv - synchronous group ROM of {last, base} parity-check words
module enc_addr_rom
    import ldpc_enc_pkg::*;
(
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic [ROM_AW-1:0] addr,
    output rom_word_t         data
);

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            data <= '0;
        end else begin
            data <= ROM_IMG[addr];
        end
    end

endmodule

// File: rtl/ldpc_encoder_8640.sv
// rtl/ldpc_encoder_8640.sv - rate-1/2 IRA LDPC encoder top; ENC_SKIP_ZERO_EN skips members with a zero info bit
module ldpc_encoder_8640
    import ldpc_enc_pkg::*;
(
    input  logic clk_in,
    input  logic reset_n,
    input  logic frame_start,
    input  logic info_din,
    output logic code_dout,
    output logic code_valid,
    output logic busy,
    output logic frame_finish
);

    state_t              state;
    logic [K_INFO-1:0]   info_mem;
    logic [M_PAR-1:0]    parity;
    logic                info_q;
    logic [12:0]         load_cnt;
    logic [13:0]         out_cnt;
    logic                acc;

    logic                enc_vld;
    logic [ROM_AW-1:0]   cur_addr;
    logic [ROM_AW-1:0]   row_start;
    logic [6:0]          m_cnt;
    logic [5:0]          g_cnt;
    logic [12:0]         mem_idx;
    logic [12:0]         off;

    rom_word_t           rom_q;
    logic [ROM_AW-1:0]   iss_addr;
    logic [ROM_AW-1:0]   iss_row;
    logic [ROM_AW-1:0]   next_row;
    logic [6:0]          iss_m;
    logic [5:0]          iss_g;
    logic [12:0]         iss_idx;
    logic [12:0]         iss_off;
    logic                enc_done;
    logic                skip;

    logic                accept;
    logic                wr_en;
    logic [12:0]         wr_addr;
    logic [12:0]         rd_addr;
    logic [13:0]         sum;
    logic [12:0]         tgl_addr;
    logic [13:0]         off_sum;
    logic [12:0]         off_inc;

    enc_addr_rom u_rom (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .addr    (iss_addr),
        .data    (rom_q)
    );

`ifdef ENC_SKIP_ZERO_EN
    localparam row_ptr_t ROW_PTR = build_row_ptr();
    assign skip     = enc_vld && !info_q;
    assign next_row = ROW_PTR[6'(g_cnt + 6'd1)];
`else
    assign skip     = 1'b0;
    assign next_row = cur_addr + 8'd1;
`endif

    assign accept  = (state == IDLE) && frame_start && !frame_finish;
    assign wr_en   = accept || (state == LOAD);
    assign wr_addr = (state == LOAD) ? load_cnt : 13'd0;

    assign sum      = {1'b0, rom_q.base} + {1'b0, off};
    assign tgl_addr = (sum >= 14'(M_PAR)) ? 13'(sum - 14'(M_PAR)) : 13'(sum);
    assign off_sum  = {1'b0, off} + 14'(Q_STEP);
    assign off_inc  = (off_sum >= 14'(M_PAR)) ? 13'(off_sum - 14'(M_PAR)) : 13'(off_sum);

    // Next (member, entry) issue; decided from the ROM word that just arrived so the loop runs one pair per cycle.
    always_comb begin
        iss_addr = cur_addr + 8'd1;
        iss_row  = row_start;
        iss_m    = m_cnt;
        iss_g    = g_cnt;
        iss_idx  = mem_idx;
        iss_off  = off;
        enc_done = 1'b0;
        if (!enc_vld) begin
            iss_addr = '0;
            iss_row  = '0;
            iss_m    = '0;
            iss_g    = '0;
            iss_idx  = '0;
            iss_off  = '0;
        end else if (rom_q.last || skip) begin
            iss_idx = mem_idx + 13'd1;
            if (m_cnt == 7'(GRP_SIZE - 1)) begin
                enc_done = (g_cnt == 6'(N_GROUPS - 1));
                iss_g    = g_cnt + 6'd1;
                iss_m    = '0;
                iss_off  = '0;
                iss_addr = next_row;
                iss_row  = next_row;
            end else begin
                iss_m    = m_cnt + 7'd1;
                iss_off  = off_inc;
                iss_addr = row_start;
            end
        end
    end

    always_comb begin
        rd_addr = '0;
        if (state == ENC) begin
            rd_addr = enc_done ? 13'd0 : iss_idx;
        end else if (state == OUT) begin
            rd_addr = (out_cnt < 14'(K_INFO - 1)) ? 13'(out_cnt + 14'd1) : 13'd0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            info_mem[wr_addr] <= info_din;
        end
        info_q <= info_mem[rd_addr];
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            code_dout    <= 1'b0;
            code_valid   <= 1'b0;
            busy         <= 1'b0;
            frame_finish <= 1'b0;
            parity       <= '0;
            load_cnt     <= '0;
            out_cnt      <= '0;
            acc          <= 1'b0;
            enc_vld      <= 1'b0;
            cur_addr     <= '0;
            row_start    <= '0;
            m_cnt        <= '0;
            g_cnt        <= '0;
            mem_idx      <= '0;
            off          <= '0;
        end else begin
            frame_finish <= 1'b0;
            case (state)
                IDLE: begin
                    parity  <= '0;
                    acc     <= 1'b0;
                    enc_vld <= 1'b0;
                    out_cnt <= '0;
                    if (accept) begin
                        state    <= LOAD;
                        load_cnt <= 13'd1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    load_cnt <= load_cnt + 13'd1;
                    if (load_cnt == 13'(K_INFO - 1)) begin
                        state <= ENC;
                    end
                end
                ENC: begin
                    enc_vld   <= 1'b1;
                    cur_addr  <= iss_addr;
                    row_start <= iss_row;
                    m_cnt     <= iss_m;
                    g_cnt     <= iss_g;
                    mem_idx   <= iss_idx;
                    off       <= iss_off;
                    if (enc_vld && info_q) begin
                        parity[tgl_addr] <= ~parity[tgl_addr];
                    end
                    if (enc_done) begin
                        state   <= OUT;
                        out_cnt <= '0;
                    end
                end
                OUT: begin
                    if (out_cnt == 14'(N_CODE)) begin
                        code_valid   <= 1'b0;
                        code_dout    <= 1'b0;
                        frame_finish <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        code_valid <= 1'b1;
                        out_cnt    <= out_cnt + 14'd1;
                        if (out_cnt < 14'(K_INFO)) begin
                            code_dout <= info_q;
                        end else begin
                            // Parity drains LSB-first through the accumulator.
                            code_dout <= acc ^ parity[0];
                            acc       <= acc ^ parity[0];
                            parity    <= parity >> 1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ldpc_encoder_8640.sv
// tb/tb_ldpc_encoder_8640.sv - frame-level directed bench for ldpc_encoder_8640
module tb_ldpc_encoder_8640;

    localparam int K   = 4320;
    localparam int N   = 8640;
    localparam int LAT = 4320 + 75 * 72 + 2;

    logic clk_in = 1'b0;
    logic reset_n = 1'b0;
    logic frame_start = 1'b0;
    logic info_din = 1'b0;
    logic code_dout;
    logic code_valid;
    logic busy;
    logic frame_finish;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    ldpc_encoder_8640 dut (
        .clk_in       (clk_in),
        .reset_n      (reset_n),
        .frame_start  (frame_start),
        .info_din     (info_din),
        .code_dout    (code_dout),
        .code_valid   (code_valid),
        .busy         (busy),
        .frame_finish (frame_finish)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        string name;
        int    kind;
        bit    poke;
        int    exp_lat;
        int    exp_ones;
    } frame_vec_t;

    typedef struct {
        int   idx;
        logic bit_exp;
    } spot_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] golden(input logic [K-1:0] info);
        logic [K-1:0] p;
        logic [N-1:0] cw;
        logic         a;
        int           g;
        int           m;
        p = '0;
        for (int i = 0; i < K; i++) begin
            if (info[i]) begin
                g = i / 72;
                m = i % 72;
                p[(g * 71 + m * 60) % K] ^= 1'b1;
                if (g % 4 == 0) p[(2160 + g * 13 + m * 60) % K] ^= 1'b1;
            end
        end
        cw[K-1:0] = info;
        a = 1'b0;
        for (int k = 0; k < K; k++) begin
            a = a ^ p[k];
            cw[K + k] = a;
        end
        return cw;
    endfunction

    task automatic send_info(input logic [K-1:0] info, input bit poke);
        frame_start = 1'b1;
        info_din    = info[0];
        for (int i = 1; i < K; i++) begin
            @(negedge clk_in);
            frame_start = poke && (i == 100);
            info_din    = info[i];
            if (poke && i == 100) chk("busy_load_poke", {31'd0, busy}, 1);
        end
        @(negedge clk_in);
        frame_start = 1'b0;
        info_din    = 1'b0;
    endtask

    task automatic drain(input logic [N-1:0] exp, input int start, input int exp_lat,
                         input bit poke, output logic [N-1:0] got);
        int t;
        int gaps;
        int first;
        got = '0;
        t = 0;
        while (code_valid !== 1'b1 && t < 20000) begin
            @(negedge clk_in);
            frame_start = poke && (t == 2000);
            if (poke && t == 2000) chk("busy_enc_poke", {31'd0, busy}, 1);
            t++;
        end
        frame_start = 1'b0;
        chk("first_valid_seen", {31'd0, code_valid}, 1);
        if (code_valid !== 1'b1) return;
        chk("latency", cyc - start, exp_lat);
        gaps = 0;
        for (int j = 0; j < N; j++) begin
            if (code_valid !== 1'b1) gaps++;
            if (frame_finish !== 1'b0) gaps++;
            got[j] = code_dout;
            @(negedge clk_in);
            frame_start = poke && (j == 1000);
            if (poke && j == 1000) chk("busy_out_poke", {31'd0, busy}, 1);
        end
        frame_start = 1'b0;
        chk("valid_window", gaps, 0);
        total++;
        if (got !== exp) begin
            bad++;
            first = -1;
            for (int j = N - 1; j >= 0; j--) if (got[j] !== exp[j]) first = j;
            $display("FAIL codeword: first bad bit %0d got %b expected %b", first, got[first], exp[first]);
        end
        chk("valid_low_after", {31'd0, code_valid}, 0);
        chk("finish_pulse", {31'd0, frame_finish}, 1);
        @(negedge clk_in);
        chk("finish_one_cycle", {31'd0, frame_finish}, 0);
        chk("busy_idle", {31'd0, busy}, 0);
    endtask

    function automatic logic [K-1:0] make_info(input int kind);
        logic [K-1:0] v;
        v = '0;
        if (kind == 1) v[0] = 1'b1;
        if (kind == 2) for (int i = 0; i < K; i++) v[i] = 1'($urandom_range(0, 1));
        if (kind == 3) v = '1;
        return v;
    endfunction

    initial begin
        frame_vec_t   frames[3];
        spot_t        spots[7];
        logic [K-1:0] info;
        logic [N-1:0] exp;
        logic [N-1:0] got;
        int           start;

        frames[0] = '{name: "all_zero",   kind: 0, poke: 1'b0, exp_lat: LAT, exp_ones: 0};
        frames[1] = '{name: "single_bit", kind: 1, poke: 1'b0, exp_lat: LAT, exp_ones: 2161};
        frames[2] = '{name: "random_pk",  kind: 2, poke: 1'b1, exp_lat: LAT, exp_ones: -1};

        spots[0] = '{idx: 0,    bit_exp: 1'b1};
        spots[1] = '{idx: 1,    bit_exp: 1'b0};
        spots[2] = '{idx: 4319, bit_exp: 1'b0};
        spots[3] = '{idx: 4320, bit_exp: 1'b1};
        spots[4] = '{idx: 6479, bit_exp: 1'b1};
        spots[5] = '{idx: 6480, bit_exp: 1'b0};
        spots[6] = '{idx: 8639, bit_exp: 1'b0};

        repeat (3) @(negedge clk_in);
        chk("rst_code_dout", {31'd0, code_dout}, 0);
        chk("rst_code_valid", {31'd0, code_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_frame_finish", {31'd0, frame_finish}, 0);
        reset_n = 1'b1;
        @(negedge clk_in);

        // Frames run back to back: each starts the cycle after the previous frame_finish.
        for (int f = 0; f < 3; f++) begin
            info  = make_info(frames[f].kind);
            exp   = golden(info);
            start = cyc;
            send_info(info, frames[f].poke);
            drain(exp, start, frames[f].exp_lat, frames[f].poke, got);
            if (frames[f].exp_ones >= 0) chk({frames[f].name, "_ones"}, $countones(got), frames[f].exp_ones);
            if (frames[f].kind == 1) begin
                for (int s = 0; s < 7; s++) begin
                    chk($sformatf("spot_%0d", spots[s].idx), {31'd0, got[spots[s].idx]}, {31'd0, spots[s].bit_exp});
                end
            end
        end

        info = make_info(3);
        send_info(info, 1'b0);
        repeat (500) @(negedge clk_in);
        chk("busy_mid_enc", {31'd0, busy}, 1);
        reset_n = 1'b0;
        #1;
        chk("abort_code_valid", {31'd0, code_valid}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_frame_finish", {31'd0, frame_finish}, 0);
        chk("abort_code_dout", {31'd0, code_dout}, 0);
        @(negedge clk_in);
        reset_n = 1'b1;
        @(negedge clk_in);

        info  = make_info(2);
        exp   = golden(info);
        start = cyc;
        send_info(info, 1'b0);
        drain(exp, start, LAT, 1'b0, got);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
